// File: rtl/alu_operand_wb.sv
// Register file, operand issue and write-back around a combinational ALU/barrel shifter.
// Define ALU_FWD_EN to forward the in-flight result/flags instead of stalling one cycle.
module alu_operand_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_rn,
  input  logic [ADDR_W-1:0] cmd_rm,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [DATA_W-1:0] cmd_imm,
  input  logic              cmd_imm_sel,
  input  logic [4:0]        cmd_shamt,
  input  logic              cmd_rs_sel,
  input  logic [3:0]        cmd_shft_op,
  input  logic [3:0]        cmd_alu_op,
  input  logic              cmd_s,
  input  logic              cmd_wb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_shift_data,
  output logic [DATA_W-1:0] alu_shift_num,
  output logic [3:0]        alu_shft_op,
  output logic [3:0]        alu_op,
  output logic              alu_cf,
  output logic              alu_vf,
  input  logic [DATA_W-1:0] alu_f,
  input  logic [3:0]        alu_nzcv,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags_nzcv,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              s;
    logic              wb;
  } ex_t;

  logic [DATA_W-1:0] regs [NUM_REGS];
  ex_t               ex;

  logic              hz_rn, hz_rm, hz_rs, hz_flags;
  logic              accept;
  logic [DATA_W-1:0] rn_val, rm_val, rs_val;
  logic [DATA_W-1:0] shift_data, shift_num;
  logic              cf_in, vf_in;

  // Dependency of the incoming command on the op currently in EX.
  always_comb begin
    hz_rn    = ex.valid && ex.wb && (ex.rd == cmd_rn);
    hz_rm    = ex.valid && ex.wb && (ex.rd == cmd_rm) && !cmd_imm_sel;
    hz_rs    = ex.valid && ex.wb && (ex.rd == cmd_rs) && cmd_rs_sel;
    hz_flags = ex.valid && ex.s;
  end

`ifdef ALU_FWD_EN
  assign cmd_ready = !rst;
  assign rn_val    = hz_rn ? alu_f : regs[cmd_rn];
  assign rm_val    = hz_rm ? alu_f : regs[cmd_rm];
  assign rs_val    = hz_rs ? alu_f : regs[cmd_rs];
  assign cf_in     = hz_flags ? alu_nzcv[1] : flags_nzcv[1];
  assign vf_in     = hz_flags ? alu_nzcv[0] : flags_nzcv[0];
`else
  // Stall exactly one cycle; the EX write lands before the retry reads.
  assign cmd_ready = !(cmd_valid && (hz_rn || hz_rm || hz_rs || hz_flags));
  assign rn_val    = regs[cmd_rn];
  assign rm_val    = regs[cmd_rm];
  assign rs_val    = regs[cmd_rs];
  assign cf_in     = flags_nzcv[1];
  assign vf_in     = flags_nzcv[0];
`endif

  assign accept     = cmd_valid && cmd_ready;
  assign shift_data = cmd_imm_sel ? cmd_imm : rm_val;
  assign shift_num  = cmd_rs_sel ? rs_val : {{(DATA_W-5){1'b0}}, cmd_shamt};
  assign dbg_data   = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      flags_nzcv     <= '0;
      ex             <= '0;
      alu_a          <= '0;
      alu_shift_data <= '0;
      alu_shift_num  <= '0;
      alu_shft_op    <= '0;
      alu_op         <= '0;
      alu_cf         <= 1'b0;
      alu_vf         <= 1'b0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
    end else begin
      // Retire the EX op.
      if (ex.valid) begin
        if (ex.wb) regs[ex.rd] <= alu_f;
        if (ex.s)  flags_nzcv  <= alu_nzcv;
        wb_rd   <= ex.rd;
        wb_data <= alu_f;
      end
      wb_valid <= ex.valid;
      ex.valid <= accept;
      // Issue: ALU inputs hold their last values while idle.
      if (accept) begin
        ex.rd          <= cmd_rd;
        ex.s           <= cmd_s;
        ex.wb          <= cmd_wb;
        alu_a          <= rn_val;
        alu_shift_data <= shift_data;
        alu_shift_num  <= shift_num;
        alu_shft_op    <= cmd_shft_op;
        alu_op         <= cmd_alu_op;
        alu_cf         <= cf_in;
        alu_vf         <= vf_in;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_wb.sv
// Bench for alu_operand_wb: a behavioural ALU closes the loop; a sequential-ISA model
// predicts issued operands, write-backs, flags and register contents every cycle.
module tb_alu_operand_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_rn, cmd_rm, cmd_rs, cmd_rd;
  logic [31:0] cmd_imm;
  logic        cmd_imm_sel, cmd_rs_sel, cmd_s, cmd_wb;
  logic [4:0]  cmd_shamt;
  logic [3:0]  cmd_shft_op, cmd_alu_op;
  logic [31:0] alu_a, alu_shift_data, alu_shift_num, alu_f;
  logic [3:0]  alu_shft_op, alu_op, alu_nzcv;
  logic        alu_cf, alu_vf;
  logic        wb_valid;
  logic [3:0]  wb_rd, flags_nzcv, dbg_addr;
  logic [31:0] wb_data, dbg_data;

  always #5 clk = ~clk;

  alu_operand_wb dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_imm_sel(cmd_imm_sel), .cmd_shamt(cmd_shamt),
    .cmd_rs_sel(cmd_rs_sel), .cmd_shft_op(cmd_shft_op), .cmd_alu_op(cmd_alu_op),
    .cmd_s(cmd_s), .cmd_wb(cmd_wb), .alu_a(alu_a), .alu_shift_data(alu_shift_data),
    .alu_shift_num(alu_shift_num), .alu_shft_op(alu_shft_op), .alu_op(alu_op),
    .alu_cf(alu_cf), .alu_vf(alu_vf), .alu_f(alu_f), .alu_nzcv(alu_nzcv),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .flags_nzcv(flags_nzcv),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ARM-flavoured ALU: returns {N,Z,C,V,F}.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, sd, sn,
                                         input logic [3:0] sop, op, input logic cf, vf);
    logic [31:0] b, x, y, f;
    logic [63:0] dd;
    logic [32:0] sum;
    logic        cin, c, v, arith;
    dd = {sd, sd} >> sn[4:0];
    case (sop[1:0])
      2'd0:    b = (sn >= 32) ? 32'd0 : sd << sn[4:0];
      2'd1:    b = (sn >= 32) ? 32'd0 : sd >> sn[4:0];
      2'd2:    b = (sn >= 32) ? {32{sd[31]}} : 32'($signed(sd) >>> sn[4:0]);
      default: b = dd[31:0];
    endcase
    arith = 1'b1; x = a; y = b; cin = 1'b0;
    case (op)
      4'd4: ;
      4'd5: cin = cf;
      4'd2: begin y = ~b; cin = 1'b1; end
      4'd3: begin x = b; y = ~a; cin = 1'b1; end
      4'd6: begin y = ~b; cin = cf; end
      4'd7: begin x = b; y = ~a; cin = cf; end
      default: arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
    if (arith) begin
      f = sum[31:0]; c = sum[32]; v = (x[31] == y[31]) && (f[31] != x[31]);
    end else begin
      c = cf; v = vf;
      case (op)
        4'd0:    f = a & b;
        4'd12:   f = a | b;
        4'd13:   f = b;
        4'd14:   f = a & ~b;
        4'd15:   f = ~b;
        default: f = a ^ b;
      endcase
    end
    return {f[31], (f == 32'd0), c, v, f};
  endfunction

  assign {alu_nzcv, alu_f} = alu_fn(alu_a, alu_shift_data, alu_shift_num,
                                    alu_shft_op, alu_op, alu_cf, alu_vf);

  int checks = 0, errors = 0, stall_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: commands execute in program order against areg/aflg at accept time;
  // creg/cflg is the architecturally visible state two edges later.
  typedef struct packed {
    logic        v;
    logic [31:0] a, sd, sn;
    logic [3:0]  sop, op;
    logic        cf, vf;
    logic [3:0]  rd;
    logic        s, wb;
    logic [31:0] f;
    logic [3:0]  nzcv;
  } rec_t;

  rec_t        p1 = '0, p2 = '0;
  logic [31:0] areg [16];
  logic [31:0] creg [16];
  logic [3:0]  aflg = '0, cflg = '0;
  bit          was_rst = 1'b0;

  initial for (int i = 0; i < 16; i++) begin areg[i] = '0; creg[i] = '0; end

  always @(negedge clk) begin
    rec_t        n;
    logic [35:0] r;
    bit          hz;
    if (was_rst) begin
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_sd", alu_shift_data, 0);
      chk("rst_alu_sn", alu_shift_num, 0);
      chk("rst_alu_ops", {alu_shft_op, alu_op, alu_cf, alu_vf}, 0);
      chk("rst_wb", {wb_rd, wb_data}, 0);
    end
    if (p1.v) begin
      chk("issue_a", alu_a, p1.a);
      chk("issue_sd", alu_shift_data, p1.sd);
      chk("issue_sn", alu_shift_num, p1.sn);
      chk("issue_ops", {alu_shft_op, alu_op, alu_cf, alu_vf}, {p1.sop, p1.op, p1.cf, p1.vf});
    end
    chk("wb_valid", wb_valid, p2.v);
    if (p2.v) begin
      chk("wb_rd", wb_rd, p2.rd);
      chk("wb_data", wb_data, p2.f);
      if (p2.wb) creg[p2.rd] = p2.f;
      if (p2.s)  cflg = p2.nzcv;
    end
    chk("flags", flags_nzcv, cflg);
    chk("dbg_data", dbg_data, creg[dbg_addr]);
    hz = p1.v && cmd_valid && (p1.s || (p1.wb && ((p1.rd == cmd_rn) ||
         (p1.rd == cmd_rm && !cmd_imm_sel) || (p1.rd == cmd_rs && cmd_rs_sel))));
`ifdef ALU_FWD_EN
    chk("cmd_ready", cmd_ready, !rst);
`else
    chk("cmd_ready", cmd_ready, !hz);
`endif
    if (cmd_valid && !cmd_ready && !rst) stall_cnt++;
    if (rst) begin
      p1 = '0; p2 = '0; aflg = '0; cflg = '0; was_rst = 1'b1;
      for (int i = 0; i < 16; i++) begin areg[i] = '0; creg[i] = '0; end
    end else begin
      was_rst = 1'b0;
      p2 = p1;
      n = '0;
      if (cmd_valid && cmd_ready) begin
        n.v   = 1'b1;
        n.a   = areg[cmd_rn];
        n.sd  = cmd_imm_sel ? cmd_imm : areg[cmd_rm];
        n.sn  = cmd_rs_sel ? areg[cmd_rs] : {27'd0, cmd_shamt};
        n.sop = cmd_shft_op; n.op = cmd_alu_op;
        n.cf  = aflg[1]; n.vf = aflg[0];
        n.rd  = cmd_rd; n.s = cmd_s; n.wb = cmd_wb;
        r = alu_fn(n.a, n.sd, n.sn, n.sop, n.op, n.cf, n.vf);
        n.f = r[31:0]; n.nzcv = r[35:32];
        if (n.wb) areg[n.rd] = n.f;
        if (n.s)  aflg = n.nzcv;
      end
      p1 = n;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] rn, rm, rs, rd, input logic [31:0] imm,
                      input logic isel, input logic [4:0] sh, input logic rsel,
                      input logic [3:0] sop, op, input logic s, wb);
    int n = 0;
    cmd_rn = rn; cmd_rm = rm; cmd_rs = rs; cmd_rd = rd; cmd_imm = imm;
    cmd_imm_sel = isel; cmd_shamt = sh; cmd_rs_sel = rsel;
    cmd_shft_op = sop; cmd_alu_op = op; cmd_s = s; cmd_wb = wb; cmd_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!cmd_ready && n < 10);
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic mov(input logic [3:0] rd, input logic [31:0] imm);
    send(4'd0, 4'd0, 4'd0, rd, imm, 1'b1, 5'd0, 1'b0, 4'd0, 4'd13, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rn = '0; cmd_rm = '0; cmd_rs = '0; cmd_rd = '0;
    cmd_imm = '0; cmd_imm_sel = 1'b0; cmd_shamt = '0; cmd_rs_sel = 1'b0;
    cmd_shft_op = '0; cmd_alu_op = '0; cmd_s = 1'b0; cmd_wb = 1'b0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state sweep.
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 chk("t1_dbg_zero", dbg_data, 0);
    end
    chk("t1_flags", flags_nzcv, 0);
    chk("t1_wb_valid", wb_valid, 0);
    idle(1);

    // R1=3; R2 = R1 + 5 with flags.
    mov(4'd1, 32'd3);
    send(4'd1, 4'd0, 4'd0, 4'd2, 32'd5, 1'b1, 5'd0, 1'b0, 4'd0, 4'd4, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("t2_wb_valid", wb_valid, 1);
    chk("t2_wb_data", wb_data, 8);
    idle(1);
    dbg_addr = 4'd2;
    #1 chk("t2_r2", dbg_data, 8);
    chk("t2_flags", flags_nzcv, 4'b0000);
    idle(1);

    // SUB R3=R1-R1 (s), then dependent ADC R4 = R3 + 7 + C back-to-back.
    s0 = stall_cnt;
    send(4'd1, 4'd1, 4'd0, 4'd3, 32'd0, 1'b0, 5'd0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b1);
    send(4'd3, 4'd0, 4'd0, 4'd4, 32'd7, 1'b1, 5'd0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b1);
    idle(3);
`ifdef ALU_FWD_EN
    chk("t3_stalls", stall_cnt - s0, 0);
`else
    chk("t3_stalls", stall_cnt - s0, 1);
`endif
    dbg_addr = 4'd3;
    #1 chk("t3_r3", dbg_data, 0);
    dbg_addr = 4'd4;
    #1 chk("t3_r4", dbg_data, 8);
    chk("t3_flags", flags_nzcv, 4'b0110);
    idle(1);

    // Independent back-to-back ops never stall.
    s0 = stall_cnt;
    mov(4'd8, 32'h11); mov(4'd9, 32'h22); mov(4'd10, 32'h33); mov(4'd11, 32'h44);
    idle(3);
    chk("t4_stalls", stall_cnt - s0, 0);
    dbg_addr = 4'd11;
    #1 chk("t4_r11", dbg_data, 32'h44);
    idle(1);

    // Reset during EX discards the in-flight write.
    mov(4'd12, 32'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_wb_valid", wb_valid, 0);
    chk("t5_flags", flags_nzcv, 0);
    dbg_addr = 4'd12;
    #1 chk("t5_r12", dbg_data, 0);
    dbg_addr = 4'd4;
    #1 chk("t5_r4", dbg_data, 0);
    idle(1);

    // Register-sourced shift amount of 33 passes through intact.
    mov(4'd5, 32'h21);
    mov(4'd6, 32'd1);
    idle(1);
    send(4'd0, 4'd6, 4'd5, 4'd7, 32'd0, 1'b0, 5'd0, 1'b1, 4'd0, 4'd13, 1'b0, 1'b1);
    chk("t6_shift_num", alu_shift_num, 33);
    chk("t6_shift_data", alu_shift_data, 1);
    idle(2);
    dbg_addr = 4'd7;
    #1 chk("t6_r7", dbg_data, 0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      dbg_addr = 4'($urandom_range(0, 15));
      if (i == 200) begin
        rst = 1'b1; idle(2); rst = 1'b0;
      end
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom, 1'($urandom), 5'($urandom),
           1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
